// File: rtl/mdu_iter_pkg.sv
// ============================================================================
//  Module      : mdu_iter_pkg
//  Description : Shared op codes, FSM state encoding and decode helpers for
//                the iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_iter_pkg;

  localparam int MD_OP_W = 3;

  // Multiply/divide operation codes issued by the core's control decoder
  typedef enum logic [MD_OP_W-1:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  // Sequencer states: IDLE waits for an op, CALC iterates, FIX writes HI/LO
  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2
  } md_state_e;

  // True for the four ops that occupy the iterative datapath
  function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  // True for the two-operand signed ops
  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

  // True for the divide ops
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
//                MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles; MTHI/MTLO
//                write in one edge. Supports flush abort and defined
//                divide-by-zero / signed-overflow results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  // Two's-complement negation at operand width
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // Two's-complement negation at product width
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  md_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  // Mul: {partial product, remaining multiplier bits}
  // Div: {partial remainder, dividend bits shifting out / quotient shifting in}
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     opnd_q;   // |multiplicand| or |divisor|
  logic [WIDTH-1:0]     araw_q;   // raw dividend, returned on divide by zero
  logic                 is_div_q;
  logic                 is_sgn_q;
  logic                 sa_q;
  logic                 sb_q;
  logic                 bzero_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       rem_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  logic                 op_sgn;
  logic                 op_div;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  // Issue-time operand conditioning: magnitudes and sign bits of signed ops
  always_comb begin
    op_sgn = md_is_signed(md_op);
    op_div = md_is_div(md_op);
    a_neg  = op_sgn & a[WIDTH-1];
    b_neg  = op_sgn & b[WIDTH-1];
    abs_a  = a_neg ? neg_w(a) : a;
    abs_b  = b_neg ? neg_w(b) : b;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    acc_d    = acc_q;
    if (is_div_q) begin
      // A clear MSB means no borrow: the divisor fits, keep the difference
      if (!rem_diff[WIDTH]) begin
        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  // Final sign correction and special-case results presented to HI/LO
  always_comb begin
    prod_fix = (is_sgn_q && (sa_q ^ sb_q)) ? neg_2w(acc_q) : acc_q;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (bzero_q) begin
        // Divide by zero: raw dividend in HI, all ones in LO, no sign fix
        fix_hi = araw_q;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_lo = (is_sgn_q && (sa_q ^ sb_q)) ? neg_w(acc_q[WIDTH-1:0])
                                               : acc_q[WIDTH-1:0];
        fix_hi = (is_sgn_q && sa_q) ? neg_w(acc_q[2*WIDTH-1:WIDTH])
                                    : acc_q[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Sequencer, iteration datapath registers and HI/LO writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        // Abort wins over everything, including a same-cycle issue or write
        state_q <= MD_ST_IDLE;
      end else begin
        case (state_q)
          MD_ST_IDLE: begin
            if (start) begin
              if (md_is_arith(md_op)) begin
                state_q  <= MD_ST_CALC;
                cnt_q    <= '0;
                is_div_q <= op_div;
                is_sgn_q <= op_sgn;
                sa_q     <= a_neg;
                sb_q     <= b_neg;
                bzero_q  <= (b == '0);
                araw_q   <= a;
                acc_q    <= op_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                opnd_q   <= op_div ? abs_b : abs_a;
              end else if (md_op == MD_OP_MTHI) begin
                hi_q <= a;
              end else if (md_op == MD_OP_MTLO) begin
                lo_q <= a;
              end
            end
          end
          MD_ST_CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q <= MD_ST_FIX;
            end
          end
          MD_ST_FIX: begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            done_q  <= 1'b1;
            state_q <= MD_ST_IDLE;
          end
          default: begin
            state_q <= MD_ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state_q != MD_ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
//  Module      : tb_mdu_iter
//  Description : Self-checking bench for mdu_iter (WIDTH=32): directed vector
//                table, multi-cycle corner sequences and randomized ops
//                against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   md_op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] eh;
    logic [W-1:0] el;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition
  function automatic void model(input logic [2:0] op, input logic [W-1:0] av,
                                input logic [W-1:0] bv,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint x;
    longint y;
    logic [63:0] q64;
    logic [63:0] r64;
    eh = '0;
    el = '0;
    case (op)
      MD_OP_MULT: begin
        x = $signed(av);
        y = $signed(bv);
        r64 = x * y;
        eh = r64[63:32];
        el = r64[31:0];
      end
      MD_OP_MULTU: begin
        r64 = {32'b0, av} * {32'b0, bv};
        eh = r64[63:32];
        el = r64[31:0];
      end
      MD_OP_DIV: begin
        if (bv == 0) begin
          eh = av;
          el = '1;
        end else begin
          x = $signed(av);
          y = $signed(bv);
          q64 = x / y;
          r64 = x % y;
          el = q64[31:0];
          eh = r64[31:0];
        end
      end
      MD_OP_DIVU: begin
        if (bv == 0) begin
          eh = av;
          el = '1;
        end else begin
          el = av / bv;
          eh = av % bv;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_OP_NONE;
  endtask

  task automatic wait_done(output int nb, output bit got);
    nb = 0;
    got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input string name, input logic [2:0] op,
                           input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
    int nb;
    bit got;
    issue(op, av, bv);
    wait_done(nb, got);
    chk({name, " done_seen"}, 64'(got), 64'd1);
    chk({name, " busy_cycles"}, 64'(nb), 64'(W + 1));
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic no_done_for(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk({name, " no_done"}, 64'(seen), 64'd0);
  endtask

  task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    issue(MD_OP_MTHI, h, '0);
    issue(MD_OP_MTLO, l, '0);
  endtask

  initial begin
    int nb;
    bit got;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic [2:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{MD_OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{MD_OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{MD_OP_DIV,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{MD_OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[6] = '{MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{MD_OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{MD_OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[9] = '{MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].eh, vecs[i].el);
    end

    // MTHI / MTLO: one edge, no busy, no done
    @(negedge clk);
    start = 1'b1; md_op = MD_OP_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; md_op = MD_OP_NONE;
    chk("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    issue(MD_OP_MTLO, 32'hCAFE_F00D, '0);
    chk("mtlo lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo hi_kept", 64'(hi), 64'hDEAD_BEEF);

    // Unknown / NONE codes have no effect
    issue(MD_OP_NONE, 32'h1111_1111, 32'h2);
    chk("none busy", 64'(busy), 64'd0);
    issue(3'd7, 32'h1111_1111, 32'h2);
    chk("code7 busy", 64'(busy), 64'd0);
    chk("code7 hi", 64'(hi), 64'hDEAD_BEEF);
    chk("code7 lo", 64'(lo), 64'hCAFE_F00D);

    // Starts while busy are dropped
    issue(MD_OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; md_op = MD_OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    md_op = MD_OP_MTHI; a = 32'h1111_2222;
    @(negedge clk);
    md_op = MD_OP_MTLO; a = 32'h3333_4444;
    @(negedge clk);
    start = 1'b0; md_op = MD_OP_NONE;
    wait_done(nb, got);
    chk("busy_start done_seen", 64'(got), 64'd1);
    chk("busy_start hi", 64'(hi), 64'd0);
    chk("busy_start lo", 64'(lo), 64'd15);
    @(negedge clk);
    chk("busy_start idle", 64'(busy), 64'd0);

    // Flush at CALC step 10
    set_hilo(32'hAAAA_0001, 32'hBBBB_0002);
    issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (10) @(negedge clk);
    chk("flush10 busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush10 busy", 64'(busy), 64'd0);
    no_done_for("flush10", 40);
    chk("flush10 hi", 64'(hi), 64'hAAAA_0001);
    chk("flush10 lo", 64'(lo), 64'hBBBB_0002);

    // Flush in FIX beats the writeback
    issue(MD_OP_DIVU, 32'd7, 32'd2);
    repeat (W) @(negedge clk);
    chk("flushfix busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushfix done", 64'(done), 64'd0);
    chk("flushfix busy", 64'(busy), 64'd0);
    chk("flushfix hi", 64'(hi), 64'hAAAA_0001);
    chk("flushfix lo", 64'(lo), 64'hBBBB_0002);

    // Flush together with start in IDLE: start ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; md_op = MD_OP_MTHI; a = 32'h5555_5555;
    @(negedge clk);
    md_op = MD_OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; md_op = MD_OP_NONE;
    chk("flushstart busy", 64'(busy), 64'd0);
    chk("flushstart hi", 64'(hi), 64'hAAAA_0001);

    // Async reset at step 20 of a MULT
    issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst20 busy", 64'(busy), 64'd0);
    chk("rst20 hi", 64'(hi), 64'd0);
    chk("rst20 lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    no_done_for("rst20", 40);
    chk("rst20 lo_after", 64'(lo), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      model(rop, ra, rb, eh, el);
      run_check($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb, eh, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
